// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pkg.sv
// Shared definitions for the OCI direct-branch compressed trace (DCT) sequencer:
// FSM state encoding, buffer geometry and small helper functions.
package nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pkg;

    localparam int DCT_ATOM_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dct_state_e;

    // Bit offset of the atom slot at a given fill level (LSB-first packing).
    function automatic logic [4:0] dct_bit_pos(input logic [DCT_CNT_W-1:0] cnt);
        return {cnt, 1'b0};
    endfunction

    // True when the accumulation buffer holds a complete frame.
    function automatic logic dct_is_full(input logic [DCT_CNT_W-1:0] cnt);
        return (cnt == DCT_CNT_W'(DCT_DEPTH));
    endfunction

endpackage

// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pack.sv
// DCT atom packer: holds the live accumulation buffer and its atom count.
// A clear and a write in the same cycle place the new atom in slot 0 of the
// freshly cleared buffer, so a frame hand-off never loses the arriving atom.
module nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pack
    import nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DCT_ATOM_W-1:0] atom,
    input  logic                  clear,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count
);

    logic [DCT_BUF_W-1:0] buf_r;
    logic [DCT_CNT_W-1:0] cnt_r;
    logic [DCT_BUF_W-1:0] buf_next_s;
    logic [DCT_CNT_W-1:0] cnt_next_s;
    logic [DCT_CNT_W-1:0] base_s;

    // Next buffer/count: optional clear first, then the write lands at the resulting position.
    always_comb begin
        buf_next_s = buf_r;
        cnt_next_s = cnt_r;
        base_s     = cnt_r;
        if (clear) begin
            buf_next_s = '0;
            cnt_next_s = 4'd0;
            base_s     = 4'd0;
        end else begin
            base_s     = cnt_r;
        end
        if (wr_en && (base_s < DCT_CNT_W'(DCT_DEPTH))) begin
            buf_next_s[dct_bit_pos(base_s) +: DCT_ATOM_W] = atom;
            cnt_next_s = base_s + 4'd1;
        end else begin
            cnt_next_s = cnt_next_s;
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_r <= '0;
            cnt_r <= 4'd0;
        end else begin
            buf_r <= buf_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign dct_buffer = buf_r;
    assign dct_count  = cnt_r;

endmodule

// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_ctrl.sv
// DCT trace sequencer top: end-of-test FSM, single-entry output frame register
// with valid/ready hand-off, and the atom packer.
// Optional feature macro: NIOS_OCI_DCT_DROP_CNT_EN adds the DROP_W parameter and
// a saturating drop_count output counting atoms lost while a full frame stalls.
module nios_system_checkers_nios2_qsys_0_oci_dct_ctrl
    import nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pkg::*;
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
#(
    parameter int DROP_W = 16
)
`endif
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  atom_valid,
    input  logic [DCT_ATOM_W-1:0] atom,
    input  logic                  end_req,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [DCT_BUF_W-1:0]  frm_data,
    output logic [DCT_CNT_W-1:0]  frm_count,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  test_ending,
    output logic                  test_has_ended
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]     drop_count
`endif
);

    dct_state_e           state_r;
    logic                 test_ending_r;
    logic                 test_has_ended_r;
    logic                 frm_valid_r;
    logic [DCT_BUF_W-1:0] frm_data_r;
    logic [DCT_CNT_W-1:0] frm_count_r;

    logic [DCT_BUF_W-1:0] dct_buffer_s;
    logic [DCT_CNT_W-1:0] dct_count_s;
    logic                 out_free_s;
    logic                 full_s;
    logic                 load_s;
    logic                 accept_s;

    // Hand-off and accept decisions for the current state.
    always_comb begin
        out_free_s = (!frm_valid_r) || frm_ready;
        full_s     = dct_is_full(dct_count_s);
        load_s     = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            ST_FILL: begin
                load_s   = full_s && out_free_s;
                accept_s = atom_valid && ((!full_s) || out_free_s);
            end
            ST_FLUSH: begin
                load_s   = (dct_count_s != 4'd0) && out_free_s;
                accept_s = 1'b0;
            end
            default: begin
                load_s   = 1'b0;
                accept_s = 1'b0;
            end
        endcase
    end

    nios_system_checkers_nios2_qsys_0_oci_dct_ctrl_pack u_pack (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (accept_s),
        .atom       (atom),
        .clear      (load_s),
        .dct_buffer (dct_buffer_s),
        .dct_count  (dct_count_s)
    );

    // End-of-test sequencer with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_FILL;
            test_ending_r    <= 1'b0;
            test_has_ended_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (end_req) begin
                        state_r       <= ST_FLUSH;
                        test_ending_r <= 1'b1;
                    end else begin
                        state_r       <= ST_FILL;
                    end
                end
                ST_FLUSH: begin
                    // Empty buffer skips straight on; otherwise wait for the partial frame to go out.
                    if ((dct_count_s == 4'd0) || out_free_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    if (!frm_valid_r) begin
                        state_r          <= ST_DONE;
                        test_ending_r    <= 1'b0;
                        test_has_ended_r <= 1'b1;
                    end else begin
                        state_r          <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r          <= ST_DONE;
                    test_ending_r    <= 1'b0;
                    test_has_ended_r <= 1'b1;
                end
                default: begin
                    state_r          <= ST_FILL;
                    test_ending_r    <= 1'b0;
                    test_has_ended_r <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry output frame register; contents hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_valid_r <= 1'b0;
            frm_data_r  <= '0;
            frm_count_r <= 4'd0;
        end else if (load_s) begin
            frm_valid_r <= 1'b1;
            frm_data_r  <= dct_buffer_s;
            frm_count_r <= dct_count_s;
        end else if (frm_valid_r && frm_ready) begin
            frm_valid_r <= 1'b0;
        end else begin
            frm_valid_r <= frm_valid_r;
        end
    end

`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    logic              drop_s;
    logic [DROP_W-1:0] drop_count_r;

    // An atom is lost only while filling with a full buffer behind a stalled frame.
    assign drop_s = (state_r == ST_FILL) && atom_valid && full_s && (!out_free_s);

    // Saturating dropped-atom counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_r <= '0;
        end else if (drop_s && (drop_count_r != {DROP_W{1'b1}})) begin
            drop_count_r <= drop_count_r + DROP_W'(1);
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`endif

    assign frm_valid      = frm_valid_r;
    assign frm_data       = frm_data_r;
    assign frm_count      = frm_count_r;
    assign dct_buffer     = dct_buffer_s;
    assign dct_count      = dct_count_s;
    assign test_ending    = test_ending_r;
    assign test_has_ended = test_has_ended_r;

endmodule

// File: tb/tb_nios_system_checkers_nios2_qsys_0_oci_dct_ctrl.sv
// Directed self-checking bench for the DCT trace sequencer.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_nios_system_checkers_nios2_qsys_0_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom = 2'b00;
    logic        end_req = 1'b0;
    logic        frm_ready = 1'b0;
    logic        frm_valid;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad = 0;

    nios_system_checkers_nios2_qsys_0_oci_dct_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .end_req        (end_req),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_data       (frm_data),
        .frm_count      (frm_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; atom_valid = 1'b0; end_req = 1'b0; frm_ready = 1'b0; atom = 2'b00;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({frm_valid, frm_data, frm_count} !== 35'd0) begin bad++; $display("FAIL reset_frm got=%0d/%h/%0d exp=0/0/0", frm_valid, frm_data, frm_count); end
        total++; if ({dct_buffer, dct_count} !== 34'd0) begin bad++; $display("FAIL reset_buf got=%h/%0d exp=0/0", dct_buffer, dct_count); end
        total++; if ({test_ending, test_has_ended} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", {test_ending, test_has_ended}); end
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
`endif
    endtask

    task automatic test_full_frame();
        do_reset();
        frm_ready = 1'b1; atom_valid = 1'b1; atom = 2'b10;
        repeat (15) tick();
        total++; if (dct_count !== 4'd15) begin bad++; $display("FAIL full_count got=%0d exp=15", dct_count); end
        total++; if (dct_buffer !== 30'h2AAAAAAA) begin bad++; $display("FAIL full_buf got=%h exp=2aaaaaaa", dct_buffer); end
        total++; if (frm_valid !== 1'b0) begin bad++; $display("FAIL full_novalid got=%0d exp=0", frm_valid); end
        // 16th atom arrives in the transfer cycle.
        tick();
        total++; if ({frm_valid, frm_count} !== {1'b1, 4'd15}) begin bad++; $display("FAIL xfer_frm got=%0d/%0d exp=1/15", frm_valid, frm_count); end
        total++; if (frm_data !== 30'h2AAAAAAA) begin bad++; $display("FAIL xfer_data got=%h exp=2aaaaaaa", frm_data); end
        total++; if ({dct_count, dct_buffer} !== {4'd1, 30'h2}) begin bad++; $display("FAIL xfer_next got=%0d/%h exp=1/2", dct_count, dct_buffer); end
        atom_valid = 1'b0;
        tick();
        total++; if (frm_valid !== 1'b0) begin bad++; $display("FAIL xfer_accept got=%0d exp=0", frm_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        frm_ready = 1'b0; atom_valid = 1'b1; atom = 2'b01;
        repeat (20) tick();
        total++; if ({frm_valid, frm_count, frm_data} !== {1'b1, 4'd15, 30'h15555555}) begin bad++; $display("FAIL stall_first got=%0d/%0d/%h exp=1/15/15555555", frm_valid, frm_count, frm_data); end
        repeat (12) tick();
        total++; if ({frm_valid, frm_count, frm_data} !== {1'b1, 4'd15, 30'h15555555}) begin bad++; $display("FAIL stall_hold got=%0d/%0d/%h exp=1/15/15555555", frm_valid, frm_count, frm_data); end
        total++; if ({dct_count, dct_buffer} !== {4'd15, 30'h15555555}) begin bad++; $display("FAIL stall_buf got=%0d/%h exp=15/15555555", dct_count, dct_buffer); end
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL stall_drop got=%0d exp=2", drop_count); end
`endif
        atom_valid = 1'b0; frm_ready = 1'b1;
        tick();
        total++; if ({frm_valid, dct_count} !== {1'b1, 4'd0}) begin bad++; $display("FAIL stall_second got=%0d/%0d exp=1/0", frm_valid, dct_count); end
        tick();
        total++; if (frm_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0d exp=0", frm_valid); end
    endtask

    task automatic test_partial_flush();
        do_reset();
        frm_ready = 1'b1; atom_valid = 1'b1;
        atom = 2'b01; tick();
        atom = 2'b11; tick();
        atom = 2'b10; end_req = 1'b1; tick();
        atom_valid = 1'b0; end_req = 1'b0;
        total++; if ({test_ending, dct_count, dct_buffer} !== {1'b1, 4'd3, 30'h2D}) begin bad++; $display("FAIL flush_enter got=%0d/%0d/%h exp=1/3/2d", test_ending, dct_count, dct_buffer); end
        tick();
        total++; if ({frm_valid, frm_count, frm_data} !== {1'b1, 4'd3, 30'h2D}) begin bad++; $display("FAIL flush_frame got=%0d/%0d/%h exp=1/3/2d", frm_valid, frm_count, frm_data); end
        total++; if ({dct_count, test_has_ended} !== {4'd0, 1'b0}) begin bad++; $display("FAIL flush_clear got=%0d/%0d exp=0/0", dct_count, test_has_ended); end
        tick();
        total++; if ({frm_valid, test_ending, test_has_ended} !== 3'b010) begin bad++; $display("FAIL flush_drain got=%b exp=010", {frm_valid, test_ending, test_has_ended}); end
        tick();
        total++; if ({test_ending, test_has_ended} !== 2'b01) begin bad++; $display("FAIL flush_done got=%b exp=01", {test_ending, test_has_ended}); end
    endtask

    task automatic test_empty_end();
        do_reset();
        frm_ready = 1'b1; end_req = 1'b1;
        tick();
        end_req = 1'b0;
        total++; if ({test_ending, test_has_ended} !== 2'b10) begin bad++; $display("FAIL empty_sample got=%b exp=10", {test_ending, test_has_ended}); end
        tick();
        total++; if ({frm_valid, test_has_ended} !== 2'b00) begin bad++; $display("FAIL empty_one got=%b exp=00", {frm_valid, test_has_ended}); end
        tick();
        total++; if ({frm_valid, test_ending, test_has_ended} !== 3'b001) begin bad++; $display("FAIL empty_two got=%b exp=001", {frm_valid, test_ending, test_has_ended}); end
        end_req = 1'b1;
        tick(); tick();
        end_req = 1'b0;
        total++; if ({test_ending, test_has_ended} !== 2'b01) begin bad++; $display("FAIL done_sticky got=%b exp=01", {test_ending, test_has_ended}); end
    endtask

    task automatic test_end_stalled();
        do_reset();
        frm_ready = 1'b0; atom_valid = 1'b1; atom = 2'b11;
        repeat (30) tick();
        total++; if ({frm_valid, dct_count} !== {1'b1, 4'd15}) begin bad++; $display("FAIL es_setup got=%0d/%0d exp=1/15", frm_valid, dct_count); end
        atom_valid = 1'b0; end_req = 1'b1;
        tick();
        end_req = 1'b0; atom_valid = 1'b1;
        repeat (3) tick();
        total++; if ({test_ending, test_has_ended, dct_count} !== {2'b10, 4'd15}) begin bad++; $display("FAIL es_flush got=%0d/%0d/%0d exp=1/0/15", test_ending, test_has_ended, dct_count); end
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL es_nodrop got=%0d exp=0", drop_count); end
`endif
        atom_valid = 1'b0; frm_ready = 1'b1;
        tick();
        total++; if ({frm_valid, frm_count, frm_data, dct_count} !== {1'b1, 4'd15, 30'h3FFFFFFF, 4'd0}) begin bad++; $display("FAIL es_frame got=%0d/%0d/%h/%0d exp=1/15/3fffffff/0", frm_valid, frm_count, frm_data, dct_count); end
        tick();
        total++; if ({frm_valid, test_has_ended} !== 2'b00) begin bad++; $display("FAIL es_drain got=%b exp=00", {frm_valid, test_has_ended}); end
        tick();
        total++; if ({test_ending, test_has_ended} !== 2'b01) begin bad++; $display("FAIL es_done got=%b exp=01", {test_ending, test_has_ended}); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        frm_ready = 1'b0; atom_valid = 1'b1; atom = 2'b01;
        repeat (22) tick();
        total++; if ({frm_valid, dct_count} !== {1'b1, 4'd7}) begin bad++; $display("FAIL mr_setup got=%0d/%0d exp=1/7", frm_valid, dct_count); end
        atom_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total++; if ({frm_valid, frm_data, frm_count, dct_buffer, dct_count, test_ending, test_has_ended} !== 71'd0) begin bad++; $display("FAIL mr_async got=%0d/%h/%0d/%h/%0d exp=all zero", frm_valid, frm_data, frm_count, dct_buffer, dct_count); end
        tick();
        reset_n = 1'b1; frm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({frm_valid, dct_count} !== {1'b0, 4'd0}) begin bad++; $display("FAIL mr_quiet got=%0d/%0d exp=0/0", frm_valid, dct_count); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_partial_flush();
        test_empty_end();
        test_end_stalled();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_checkers_nios2_qsys_0_oci_dct_ctrl.md
# nios_system_checkers_nios2_qsys_0_oci_dct_ctrl

Sequencer for the OCI direct-branch compressed trace (DCT) buffer of the Nios II debug core. It packs 2-bit trace atoms into the 30-bit `dct_buffer` and tracks occupancy in `dct_count`. It hands full or flushed frames to the trace output via a valid/ready handshake. It also runs the end-of-test sequence that drives `test_ending` and `test_has_ended` to the OCI test bench.

## Interface
Parameters:
- `DROP_W`, 16: width of the dropped-atom counter (present only with the macro).

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `atom_valid`  in  1  trace atom present this cycle.
- `atom`  in  2  atom code, opaque to this block.
- `end_req`  in  1  request to end the test; level-sensitive, sampled each cycle.
- `frm_valid`  out  1  output frame valid.
- `frm_ready`  in  1  downstream accepts the frame.
- `frm_data`  out  30  packed frame.
- `frm_count`  out  4  number of atoms in the frame, 1..15.
- `dct_buffer`  out  30  live accumulation buffer.
- `dct_count`  out  4  live atom count, 0..15.
- `test_ending`  out  1  end sequence in progress.
- `test_has_ended`  out  1  end sequence complete; sticky.
- `drop_count`  out  `DROP_W`  saturating count of dropped atoms (macro only).

## Operation
- Packing is LSB-first. An atom accepted at count k is written to `dct_buffer[2k+1:2k]` and the count becomes k+1. Bits above 2·count are zero.
- The output register (`frm_*`) holds a single entry and is "free" when `frm_valid`=0 or `frm_valid & frm_ready`.
- Transfer occurs when `dct_count`==15 and the output register is free:
  - `frm_data` ← buffer, `frm_count` ← 15, buffer cleared.
  - An atom arriving in the transfer cycle lands in the cleared buffer, so the next count is 1.
- If `dct_count`==15 and the output register is not free, incoming atoms are dropped and the buffer holds.
- FSM states:
  - FILL (reset state): accept atoms. A sampled `end_req`=1 moves to FLUSH; the atom arriving in that same cycle is still accepted.
  - FLUSH: `test_ending`=1 and atoms are ignored, not counted as drops.
    - If count>0, transfer a partial frame with `frm_count`=count once the output register is free.
    - Then move to DRAIN.
  - DRAIN: wait for `frm_valid`=0, then move to DONE.
  - DONE: `test_ending`=0, `test_has_ended`=1. The block stays here until reset and ignores `end_req`.
- `frm_data`/`frm_count` are stable while `frm_valid`=1 and `frm_ready`=0.

## Timing
- Reset values:
  - `frm_valid`=0, `frm_data`=0, `frm_count`=0.
  - `dct_buffer`=0, `dct_count`=0.
  - `test_ending`=0, `test_has_ended`=0.
  - `drop_count`=0.
  - FSM=FILL.
- Reset takes effect immediately and clears a mid-frame buffer or a pending output frame without emitting it.
- An atom accepted at edge N is visible on `dct_buffer`/`dct_count` after edge N.
- `dct_count` reaches 15 after edge N. The transfer then happens at edge N+1, with `frm_valid`=1 after N+1, given the output register is free.
- `end_req` is sampled at edge N, so `test_ending`=1 after N.
- Partial flush: the transfer happens at edge N+1 if the output register is free.
- `test_has_ended` rises at the first edge in DRAIN with `frm_valid`=0.
- With an empty buffer and idle output, `test_has_ended`=1 is visible 2 cycles after `end_req` is sampled.
- All outputs are registered.

## Configuration
- `NIOS_OCI_DCT_DROP_CNT_EN` defined:
  - `drop_count` port exists.
  - It increments by 1 per dropped atom and saturates at 2^`DROP_W`−1.
- Undefined: the port and counter are absent. Drops are silent.

## Structure
- Shared package holds:
  - FSM state enum (FILL, FLUSH, DRAIN, DONE).
  - `DCT_ATOM_W`=2, `DCT_DEPTH`=15, `DCT_BUF_W`=30.
- A sub-module is natural: `nios_system_checkers_nios2_qsys_0_oci_dct_pack`, which holds the buffer, count and write-position logic. The FSM and output register stay at top level.

## Test plan
- 15 atoms of 2'b10, back-to-back, with `frm_ready`=1:
  - `frm_data`=30'h2AAAAAAA, `frm_count`=15.
  - `dct_count` returns to 0, or to 1 if a 16th atom arrives in the transfer cycle.
- `frm_ready`=0, 32 atoms in a row:
  - First frame held stable.
  - Second buffer stays at 15.
  - `drop_count`=2 with the macro; `frm_valid` stays 1.
- Atoms 01, 11, 10 then `end_req`:
  - Partial frame with `frm_data`=30'h0000002D, `frm_count`=3.
  - `test_ending` pulses; `test_has_ended`=1 after the handshake.
- `end_req` with an empty buffer: no frame; `test_has_ended`=1 two cycles after sampling.
- `end_req` during a stalled full frame:
  - `test_has_ended` stays 0 until `frm_ready` rises.
  - Atoms during FLUSH leave `drop_count` unchanged.
- `reset_n` asserted with `dct_count`=7 and `frm_valid`=1: all outputs zero immediately; no frame is emitted after release.
